// File: rtl/csa_reduce_sched_if.sv
// Handshake and datapath bundle for csa_reduce_sched.
// pp_*: partial product stream in; csa_*: shared 3:2 row; res_*: result pair out.
interface csa_reduce_sched_if #(
    parameter int WIDTH = 66
);
    logic             pp_valid;
    logic             pp_ready;
    logic [WIDTH-1:0] pp_data;
    logic             pp_last;
    logic [WIDTH-1:0] csa_op1;
    logic [WIDTH-1:0] csa_op2;
    logic [WIDTH-1:0] csa_op3;
    logic [WIDTH-1:0] csa_s;
    logic [WIDTH-1:0] csa_c;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic [WIDTH-1:0] res_carry;

    // Environment side: upstream producer, CSA row and downstream adder.
    modport master (
        output pp_valid, pp_data, pp_last,
        output csa_s, csa_c,
        output res_ready,
        input  pp_ready,
        input  csa_op1, csa_op2, csa_op3,
        input  res_valid, res_sum, res_carry
    );

    // Scheduler side.
    modport slave (
        input  pp_valid, pp_data, pp_last,
        input  csa_s, csa_c,
        input  res_ready,
        output pp_ready,
        output csa_op1, csa_op2, csa_op3,
        output res_valid, res_sum, res_carry
    );
endinterface

// File: rtl/csa_reduce_sched.sv
// Iterative Wallace reduction scheduler driving one shared CSA row.
// Ports: clk, rst (async high), bus (pp in, csa row, res out).
module csa_reduce_sched #(
    parameter int WIDTH  = 66,
    parameter int NUM_PP = 17
) (
    input logic               clk,
    input logic               rst,
    csa_reduce_sched_if.slave bus
);
    localparam int PW = $clog2(NUM_PP);
    localparam int CW = $clog2(NUM_PP + 1);
    localparam int TW = PW + 2;

    typedef logic [PW-1:0]    ptr_t;
    typedef logic [CW-1:0]    cnt_t;
    typedef logic [TW-1:0]    tmp_t;
    typedef logic [WIDTH-1:0] vec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_DONE,
        S_OUT
    } state_t;

    state_t state_q, state_d;
    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    cnt_t   count_q, count_d;
    vec_t   queue_q [NUM_PP];
    vec_t   queue_d [NUM_PP];
    logic   res_valid_q, res_valid_d;
    vec_t   res_sum_q, res_sum_d;
    vec_t   res_carry_q, res_carry_d;

    logic   pp_ready;
    vec_t   op1, op2, op3;
    ptr_t   head_p1, head_p2, tail_p1;

    // Pointer advance modulo NUM_PP; k never exceeds NUM_PP.
    function automatic ptr_t wrap_add(ptr_t p, int unsigned k);
        tmp_t t;
        t = tmp_t'(p) + tmp_t'(k);
        if (t >= tmp_t'(NUM_PP)) begin
            t = t - tmp_t'(NUM_PP);
        end
        return t[PW-1:0];
    endfunction

    assign head_p1 = wrap_add(head_q, 1);
    assign head_p2 = wrap_add(head_q, 2);
    assign tail_p1 = wrap_add(tail_q, 1);

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        queue_d     = queue_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_carry_d = res_carry_q;
        pp_ready    = 1'b0;
        op1         = '0;
        op2         = '0;
        op3         = '0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                pp_ready = 1'b1;
                if (bus.pp_valid) begin
                    queue_d[tail_q] = bus.pp_data;
                    tail_d  = tail_p1;
                    count_d = count_q + cnt_t'(1);
                    // A full queue ends the operation even without pp_last.
                    if (bus.pp_last || count_d == cnt_t'(NUM_PP)) begin
                        state_d = (count_d >= cnt_t'(3)) ? S_REDUCE : S_DONE;
                    end
                end
            end
            S_REDUCE: begin
                op1 = queue_q[head_q];
                op2 = queue_q[head_p1];
                op3 = queue_q[head_p2];
                // When full, tail==head: the new vectors land in slots
                // whose old contents are being consumed this cycle.
                queue_d[tail_q]  = bus.csa_s;
                queue_d[tail_p1] = bus.csa_c << 1;
                head_d  = wrap_add(head_q, 3);
                tail_d  = wrap_add(tail_q, 2);
                count_d = count_q - cnt_t'(1);
                if (count_d == cnt_t'(2)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_sum_d   = (count_q != '0) ? queue_q[head_q] : '0;
                res_carry_d = (count_q == cnt_t'(2)) ? queue_q[head_p1] : '0;
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    count_d     = '0;
                    head_d      = '0;
                    tail_d      = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_carry_q <= '0;
            for (int i = 0; i < NUM_PP; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_carry_q <= res_carry_d;
            for (int i = 0; i < NUM_PP; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end

    assign bus.pp_ready  = pp_ready;
    assign bus.csa_op1   = op1;
    assign bus.csa_op2   = op2;
    assign bus.csa_op3   = op3;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_carry = res_carry_q;
endmodule

// File: tb/tb_csa_reduce_sched.sv
// Self-checking bench for csa_reduce_sched.
// Drives the pp stream, models the CSA row, and checks results.
module tb_csa_reduce_sched;
    localparam int W  = 66;
    localparam int NP = 17;

    typedef logic [W-1:0] vec_t;
    typedef struct packed {
        vec_t a;
        vec_t b;
        vec_t c;
    } trip_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    csa_reduce_sched_if #(.WIDTH(W)) bus ();

    // Behaviour of the shared CSA row.
    assign bus.csa_s = bus.csa_op1 ^ bus.csa_op2 ^ bus.csa_op3;
    assign bus.csa_c = (bus.csa_op1 & bus.csa_op2) |
                       (bus.csa_op1 & bus.csa_op3) |
                       (bus.csa_op2 & bus.csa_op3);

    csa_reduce_sched #(.WIDTH(W), .NUM_PP(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t sum_of(input vec_t ops[$]);
        vec_t s = '0;
        foreach (ops[i]) s = s + ops[i];
        return s;
    endfunction

    // Reference: FIFO of vectors, take three, append sum then carry*2.
    function automatic void model(input vec_t ops[$], output vec_t rs,
                                  output vec_t rc, output trip_t tr[$]);
        vec_t  q[$];
        vec_t  a, b, c;
        trip_t t;
        q = ops;
        tr = {};
        while (q.size() > 2) begin
            a = q.pop_front();
            b = q.pop_front();
            c = q.pop_front();
            t = {a, b, c};
            tr.push_back(t);
            q.push_back(a ^ b ^ c);
            q.push_back(((a & b) | (a & c) | (b & c)) << 1);
        end
        rs = (q.size() > 0) ? q[0] : '0;
        rc = (q.size() > 1) ? q[1] : '0;
    endfunction

    function automatic vec_t rnd_vec();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    function automatic int trip_diff(input trip_t a[$], input trip_t b[$]);
        int bad = 0;
        if (a.size() != b.size()) return 1000 + a.size();
        foreach (a[i]) if (a[i] !== b[i]) bad++;
        return bad;
    endfunction

    task automatic run_op(input vec_t ops[$], input bit use_last,
                          input bit keep_valid, input int hold,
                          output vec_t rs, output vec_t rc,
                          output int red, output int rdy_seen,
                          output int unstable, output bit idle_ok,
                          output bit tmo, output trip_t tr[$]);
        int    i, cyc, cnt, n;
        trip_t t;
        n = ops.size();
        i = 0; cyc = 0; cnt = 0; red = 0; rdy_seen = 0; unstable = 0;
        idle_ok = 0; tmo = 0; tr = {}; rs = '0; rc = '0;
        bus.res_ready = (hold == 0);
        while (i < n && !tmo) begin
            @(negedge clk);
            cyc++;
            bus.pp_valid = 1'b1;
            bus.pp_data  = ops[i];
            bus.pp_last  = use_last && (i == n - 1);
            if (bus.pp_ready === 1'b1) i++;
            if (cyc > 200) tmo = 1;
        end
        @(negedge clk);
        bus.pp_valid = keep_valid;
        bus.pp_data  = keep_valid ? rnd_vec() : '0;
        bus.pp_last  = 1'b0;
        while (bus.res_valid !== 1'b1 && !tmo) begin
            t = {bus.csa_op1, bus.csa_op2, bus.csa_op3};
            tr.push_back(t);
            if (bus.pp_ready === 1'b1) rdy_seen++;
            cnt++;
            if (cnt > 300) tmo = 1;
            else @(negedge clk);
        end
        red = cnt - 1;
        if (tr.size() > 0) void'(tr.pop_back());
        if (tmo) begin
            bus.pp_valid = 1'b0;
            return;
        end
        rs = bus.res_sum;
        rc = bus.res_carry;
        for (int k = 0; k < hold; k++) begin
            if (bus.pp_ready === 1'b1) rdy_seen++;
            if (bus.res_valid !== 1'b1 || bus.res_sum !== rs ||
                bus.res_carry !== rc) unstable++;
            @(negedge clk);
        end
        if (bus.res_valid !== 1'b1 || bus.res_sum !== rs ||
            bus.res_carry !== rc) unstable++;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.pp_valid = 1'b0;
        bus.pp_data  = '0;
        idle_ok = (bus.res_valid === 1'b0) && (bus.pp_ready === 1'b0);
        @(negedge clk);
        idle_ok = idle_ok && (bus.pp_ready === 1'b1);
    endtask

    task automatic test_reset();
        bus.pp_valid = 0; bus.pp_data = '0; bus.pp_last = 0; bus.res_ready = 0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.pp_ready !== 1'b0) begin fails++; $display("FAIL rst_pp_ready: got %b want 0", bus.pp_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.res_sum !== '0) begin fails++; $display("FAIL rst_res_sum: got %h want 0", bus.res_sum); end
        checks++; if (bus.res_carry !== '0) begin fails++; $display("FAIL rst_res_carry: got %h want 0", bus.res_carry); end
        checks++; if ((bus.csa_op1 | bus.csa_op2 | bus.csa_op3) !== '0) begin fails++; $display("FAIL rst_csa_ops: got %h/%h/%h want 0", bus.csa_op1, bus.csa_op2, bus.csa_op3); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.pp_ready !== 1'b1) begin fails++; $display("FAIL rst_then_load: got %b want 1", bus.pp_ready); end
    endtask

    task automatic test_three();
        vec_t ops[$] = '{66'd3, 66'd5, 66'd7};
        vec_t rs, rc; int red, rdy, uns; bit idl, tmo; trip_t tr[$];
        trip_t t0 = {66'd3, 66'd5, 66'd7};
        run_op(ops, 1, 0, 0, rs, rc, red, rdy, uns, idl, tmo, tr);
        checks++; if (tmo !== 1'b0) begin fails++; $display("FAIL three_timeout: got %b want 0", tmo); end
        checks++; if (rs !== 66'd1) begin fails++; $display("FAIL three_sum: got %h want 1", rs); end
        checks++; if (rc !== 66'd14) begin fails++; $display("FAIL three_carry: got %h want e", rc); end
        checks++; if (red !== 1) begin fails++; $display("FAIL three_cycles: got %0d want 1", red); end
        checks++; if (tr.size() != 1 || tr[0] !== t0) begin fails++; $display("FAIL three_ops: got %0d triples want 1 of 3/5/7", tr.size()); end
        checks++; if (idl !== 1'b1) begin fails++; $display("FAIL three_idle: got %b want 1", idl); end
    endtask

    task automatic test_forced_last();
        vec_t ops[$]; vec_t rs, rc, ms, mc; int red, rdy, uns; bit idl, tmo;
        trip_t tr[$], mtr[$];
        for (int i = 0; i < NP; i++) ops.push_back(66'd1);
        model(ops, ms, mc, mtr);
        run_op(ops, 0, 1, 0, rs, rc, red, rdy, uns, idl, tmo, tr);
        checks++; if (tmo !== 1'b0) begin fails++; $display("FAIL forced_timeout: got %b want 0", tmo); end
        checks++; if (vec_t'(rs + rc) !== vec_t'(NP)) begin fails++; $display("FAIL forced_total: got %h want %h", vec_t'(rs + rc), vec_t'(NP)); end
        checks++; if (red !== NP - 2) begin fails++; $display("FAIL forced_cycles: got %0d want %0d", red, NP - 2); end
        checks++; if (rdy !== 0) begin fails++; $display("FAIL forced_pp_ready: got %0d high cycles want 0", rdy); end
        checks++; if (rs !== ms || rc !== mc) begin fails++; $display("FAIL forced_pair: got %h/%h want %h/%h", rs, rc, ms, mc); end
        checks++; if (trip_diff(tr, mtr) !== 0) begin fails++; $display("FAIL forced_ops: got %0d bad triples want 0", trip_diff(tr, mtr)); end
        checks++; if (idl !== 1'b1) begin fails++; $display("FAIL forced_idle: got %b want 1", idl); end
    endtask

    task automatic test_small();
        vec_t one[$] = '{66'h2A};
        vec_t two[$] = '{66'd9, 66'd6};
        vec_t rs, rc; int red, rdy, uns; bit idl, tmo; trip_t tr[$];
        run_op(one, 1, 0, 0, rs, rc, red, rdy, uns, idl, tmo, tr);
        checks++; if (rs !== 66'h2A || rc !== '0) begin fails++; $display("FAIL single_pair: got %h/%h want 2a/0", rs, rc); end
        checks++; if (red !== 0 || tmo !== 1'b0) begin fails++; $display("FAIL single_cycles: got %0d tmo %b want 0", red, tmo); end
        run_op(two, 1, 0, 0, rs, rc, red, rdy, uns, idl, tmo, tr);
        checks++; if (rs !== 66'd9 || rc !== 66'd6) begin fails++; $display("FAIL pair_pair: got %h/%h want 9/6", rs, rc); end
        checks++; if (red !== 0 || tmo !== 1'b0) begin fails++; $display("FAIL pair_cycles: got %0d tmo %b want 0", red, tmo); end
    endtask

    task automatic test_overflow();
        vec_t ops[$]; vec_t rs, rc, ms, mc, all1; int red, rdy, uns; bit idl, tmo;
        trip_t tr[$], mtr[$];
        all1 = '1;
        ops = '{all1, all1, all1};
        model(ops, ms, mc, mtr);
        run_op(ops, 1, 0, 0, rs, rc, red, rdy, uns, idl, tmo, tr);
        checks++; if (vec_t'(rs + rc) !== vec_t'(all1 - 66'd2)) begin fails++; $display("FAIL ovf_total: got %h want %h", vec_t'(rs + rc), vec_t'(all1 - 66'd2)); end
        checks++; if (rc[0] !== 1'b0) begin fails++; $display("FAIL ovf_carry_lsb: got %b want 0", rc[0]); end
        checks++; if (rs !== ms || rc !== mc) begin fails++; $display("FAIL ovf_pair: got %h/%h want %h/%h", rs, rc, ms, mc); end
    endtask

    task automatic test_backpressure();
        vec_t ops[$]; vec_t rs, rc, ms, mc; int red, rdy, uns; bit idl, tmo;
        trip_t tr[$], mtr[$];
        for (int i = 0; i < 5; i++) ops.push_back(rnd_vec());
        model(ops, ms, mc, mtr);
        run_op(ops, 1, 0, 10, rs, rc, red, rdy, uns, idl, tmo, tr);
        checks++; if (uns !== 0 || tmo !== 1'b0) begin fails++; $display("FAIL bp_stable: got %0d unstable cycles want 0", uns); end
        checks++; if (rdy !== 0) begin fails++; $display("FAIL bp_pp_ready: got %0d high cycles want 0", rdy); end
        checks++; if (rs !== ms || rc !== mc) begin fails++; $display("FAIL bp_pair: got %h/%h want %h/%h", rs, rc, ms, mc); end
        checks++; if (idl !== 1'b1) begin fails++; $display("FAIL bp_idle: got %b want 1", idl); end
    endtask

    task automatic test_reset_mid();
        vec_t ops[$]; vec_t rs, rc, ms, mc; int red, rdy, uns, i, cyc; bit idl, tmo;
        trip_t tr[$], mtr[$];
        vec_t ops2[$] = '{66'd1, 66'd2, 66'd3};
        for (int k = 0; k < 9; k++) ops.push_back(rnd_vec());
        model(ops, ms, mc, mtr);
        i = 0; cyc = 0;
        while (i < 9 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.pp_valid = 1'b1; bus.pp_data = ops[i]; bus.pp_last = (i == 8);
            if (bus.pp_ready === 1'b1) i++;
        end
        checks++; if (i !== 9) begin fails++; $display("FAIL mid_load: got %0d beats want 9", i); end
        @(negedge clk);
        bus.pp_valid = 1'b0; bus.pp_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.csa_op1 !== mtr[3].a || bus.csa_op3 !== mtr[3].c) begin fails++; $display("FAIL mid_op4: got %h/%h want %h/%h", bus.csa_op1, bus.csa_op3, mtr[3].a, mtr[3].c); end
        rst = 1'b1;
        #1;
        checks++; if ({bus.pp_ready, bus.res_valid} !== 2'b00 || bus.res_sum !== '0 || bus.res_carry !== '0) begin fails++; $display("FAIL mid_rst_outs: got %b%b %h/%h want 00 0/0", bus.pp_ready, bus.res_valid, bus.res_sum, bus.res_carry); end
        checks++; if ((bus.csa_op1 | bus.csa_op2 | bus.csa_op3) !== '0) begin fails++; $display("FAIL mid_rst_ops: got %h want 0", bus.csa_op1 | bus.csa_op2 | bus.csa_op3); end
        @(negedge clk);
        rst = 1'b0;
        run_op(ops2, 1, 0, 0, rs, rc, red, rdy, uns, idl, tmo, tr);
        checks++; if (vec_t'(rs + rc) !== 66'd6 || tmo !== 1'b0) begin fails++; $display("FAIL mid_after: got %h want 6", vec_t'(rs + rc)); end
    endtask

    task automatic test_random();
        vec_t ops[$]; vec_t rs, rc, ms, mc; int red, rdy, uns, n, hold; bit idl, tmo, last;
        trip_t tr[$], mtr[$];
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, NP);
            hold = $urandom_range(0, 3);
            last = (n < NP) ? 1'b1 : 1'($urandom_range(0, 1));
            ops = {};
            for (int k = 0; k < n; k++) ops.push_back((it % 3 == 0) ? vec_t'($urandom_range(0, 255)) : rnd_vec());
            model(ops, ms, mc, mtr);
            run_op(ops, last, 0, hold, rs, rc, red, rdy, uns, idl, tmo, tr);
            checks++; if (rs !== ms || rc !== mc || tmo !== 1'b0) begin fails++; $display("FAIL rnd_pair[%0d]: got %h/%h want %h/%h", it, rs, rc, ms, mc); end
            checks++; if (vec_t'(rs + rc) !== sum_of(ops)) begin fails++; $display("FAIL rnd_sum[%0d]: got %h want %h", it, vec_t'(rs + rc), sum_of(ops)); end
            checks++; if (red !== ((n > 2) ? n - 2 : 0)) begin fails++; $display("FAIL rnd_cycles[%0d]: got %0d want %0d", it, red, (n > 2) ? n - 2 : 0); end
            checks++; if (trip_diff(tr, mtr) !== 0) begin fails++; $display("FAIL rnd_ops[%0d]: got %0d bad triples want 0", it, trip_diff(tr, mtr)); end
            checks++; if (uns !== 0 || idl !== 1'b1) begin fails++; $display("FAIL rnd_hs[%0d]: got unstable %0d idle %b want 0/1", it, uns, idl); end
        end
    endtask

    initial begin
        test_reset();
        test_three();
        test_forced_last();
        test_small();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/csa_reduce_sched.md
Name: csa_reduce_sched

Overview:
- Iterative Wallace-tree reduction scheduler for one shared carry-save adder row (3:2 compressor, WIDTH bits).
- Accepts a stream of partial products into an operand queue.
- Time-multiplexes the single CSA row: each cycle it retires three queued operands and enqueues the resulting sum and shifted carry vectors, until two vectors remain.
- Presents the final sum/carry pair to the downstream carry-propagate adder with a valid/ready handshake.

Parameters:
- WIDTH, 66, bit width of every operand, CSA port and result vector.
- NUM_PP, 17, maximum partial products per operation (queue depth); legal range 3..64.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pp_valid  input  1  partial product offered.
- pp_ready  output  1  scheduler accepts pp_data this cycle.
- pp_data  input  WIDTH  partial product.
- pp_last  input  1  marks the final partial product of the operation.
- csa_op1  output  WIDTH  to shared CSA row, operand A.
- csa_op2  output  WIDTH  to shared CSA row, operand B.
- csa_op3  output  WIDTH  to shared CSA row, operand C.
- csa_s  input  WIDTH  CSA bitwise sum (combinational return).
- csa_c  input  WIDTH  CSA bitwise carry, unshifted (bit i = carry out of column i).
- res_valid  output  1  result pair valid.
- res_ready  input  1  downstream accepts result.
- res_sum  output  WIDTH  final sum vector.
- res_carry  output  WIDTH  final carry vector, already weight-aligned.

Behaviour:
- Reset (async, any state): state=IDLE, queue count=0, pp_ready=0, res_valid=0, res_sum=0, res_carry=0, csa_op1/2/3=0.
- Queue: circular register array, NUM_PP entries, head/tail pointers wrap modulo NUM_PP, plus count. FIFO order; oldest at head.
- IDLE: pp_ready=0. Next cycle goes to LOAD.
- LOAD: pp_ready=1.
  - On pp_valid&pp_ready: push pp_data, count+1.
  - Leave LOAD on an accepted beat with pp_last=1, or when the accept makes count==NUM_PP (forced last; later beats wait for the next operation).
  - Next state is REDUCE if the final count>=3, else DONE.
- REDUCE: pp_ready=0.
  - csa_op1/2/3 = queue[head], queue[head+1], queue[head+2] (mod NUM_PP); combinational from queue state.
  - Each cycle: pop 3, then push csa_s followed by (csa_c<<1) truncated to WIDTH (bit 0 = 0, MSB carry discarded, modulo 2^WIDTH). Net count-1.
  - Goes to DONE when the updated count==2.
  - Takes exactly n-2 cycles for n loaded operands.
- Outside REDUCE, csa_op1/2/3 = 0.
- DONE: registers the output and asserts res_valid the cycle after entry.
  - count==2: res_sum=queue[head], res_carry=queue[head+1].
  - count==1: res_sum=queue[head], res_carry=0.
- OUT: res_valid=1 and res_sum/res_carry held stable until res_ready=1.
  - On handshake: res_valid=0, count=0, pointers reset, go to IDLE.
  - res_valid never drops without a handshake.
- Invariants:
  - res_sum+res_carry ≡ sum of loaded operands (mod 2^WIDTH).
  - Throughput per operation is n load cycles + max(n-2,0) + 3 cycles, with res_ready held high.
- No back-to-back overlap: a new operation starts only after OUT completes.
- pp_valid with pp_ready=0 is ignored; the upstream holds the beat.
- Reset asserted mid-LOAD/REDUCE/OUT discards all queue contents and any pending result. There is no partial output.

Test Plan:
- Load 3,5,7 (last on 7), res_ready=1 -> one REDUCE cycle with csa_op1/2/3=3/5/7. Result: res_sum=1, res_carry=14, sum 15.
- Load 17 operands of value 1 with no pp_last -> forced exit at count 17, 15 REDUCE cycles. res_sum+res_carry=17. pp_ready stays low afterwards until IDLE->LOAD.
- Load a single operand 0x2A (last) -> no REDUCE cycles, res_sum=0x2A, res_carry=0. Load two operands 9,6 -> res_sum=9, res_carry=6.
- Overflow: load 3 operands of 2^66-1 -> res_sum+res_carry mod 2^66 = 2^66-3. Carry MSB is dropped, and res_carry bit 0 is 0.
- Hold res_ready=0 for 10 cycles in OUT -> res_valid and the result are stable every cycle, and pp_ready=0. Release -> IDLE the next cycle.
- Assert rst during the 4th REDUCE cycle of a 9-operand load -> all outputs 0 immediately. After release, a new load of 1,2,3 yields the correct sum 6.
